// File: rtl/counter_seq_ctrl_pkg.sv
// Shared types and constants for the counter sequencing controller.
package counter_pkg;

    localparam int DEF_WIDTH = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_HOLD = 2'b10,
        ST_DONE = 2'b11
    } state_t;

endpackage

// File: rtl/counter_seq_ctrl_if.sv
// Control/status bundle between a controlling agent and counter_seq_ctrl.
interface counter_seq_ctrl_if #(
    parameter int WIDTH = counter_pkg::DEF_WIDTH
);
    logic             start;
    logic             stop;
    logic             pause;
    logic             oneshot;
    logic             down;
    logic [WIDTH-1:0] period;
    logic [WIDTH-1:0] out;
    logic             busy;
    logic             tc;
    logic             done;

    modport master (
        output start, stop, pause, oneshot, down, period,
        input  out, busy, tc, done
    );

    modport slave (
        input  start, stop, pause, oneshot, down, period,
        output out, busy, tc, done
    );
endinterface

// File: rtl/counter_seq_ctrl_core.sv
// Plain loadable up/down counter; load takes precedence over counting.
module counter_core #(
    parameter int WIDTH = counter_pkg::DEF_WIDTH
) (
    input  logic             clk,
    input  logic             Rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             dir,
    output logic [WIDTH-1:0] out
);
    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] out_d;

    always_comb begin
        out_d = out_q;
        if (load) begin
            out_d = load_val;
        end else if (en) begin
            out_d = dir ? out_q - WIDTH'(1) : out_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign out = out_q;
endmodule

// File: rtl/counter_seq_ctrl.sv
// Start/pause/resume/stop sequencer around counter_core with latched period and mode.
module counter_seq_ctrl
    import counter_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic              clk,
    input  logic              Rst,
    counter_seq_ctrl_if.slave bus
);
    state_t           state_q, state_d;
    logic [WIDTH-1:0] period_q, period_d;
    logic             oneshot_q, oneshot_d;
    logic             down_q, down_d;

    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             en;
    logic [WIDTH-1:0] count;
    logic [WIDTH-1:0] term;
    logic             at_term;

    assign term    = down_q ? '0 : period_q;
    assign at_term = (count == term);

    always_comb begin
        state_d   = state_q;
        period_d  = period_q;
        oneshot_d = oneshot_q;
        down_d    = down_q;
        load      = 1'b0;
        load_val  = '0;
        en        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // Keep the count pinned at zero while idle; start overrides the load value.
                load = 1'b1;
                if (bus.start && !bus.stop) begin
                    state_d   = ST_RUN;
                    period_d  = bus.period;
                    oneshot_d = bus.oneshot;
                    down_d    = bus.down;
                    load_val  = bus.down ? bus.period : '0;
                end
            end
            ST_RUN: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    load    = 1'b1;
                end else if (bus.pause) begin
                    state_d = ST_HOLD;
                end else if (at_term) begin
                    if (oneshot_q) begin
                        state_d = ST_DONE;
                    end else begin
                        load     = 1'b1;
                        load_val = down_q ? period_q : '0;
                    end
                end else begin
                    en = 1'b1;
                end
            end
            ST_HOLD: begin
                if (bus.stop) begin
                    state_d = ST_IDLE;
                    load    = 1'b1;
                end else if (!bus.pause && bus.start) begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                load    = 1'b1;
            end
            default: begin
                state_d = ST_IDLE;
                load    = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (Rst) begin
            state_q   <= ST_IDLE;
            period_q  <= '0;
            oneshot_q <= 1'b0;
            down_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            period_q  <= period_d;
            oneshot_q <= oneshot_d;
            down_q    <= down_d;
        end
    end

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk      (clk),
        .Rst      (Rst),
        .load     (load),
        .load_val (load_val),
        .en       (en),
        .dir      (down_q),
        .out      (count)
    );

    assign bus.out  = count;
    assign bus.busy = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign bus.tc   = (state_q == ST_RUN) && at_term;
    assign bus.done = (state_q == ST_DONE);
endmodule
